// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// State encodings, port indices and default sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  localparam int PORT_FETCH   = 0;
  localparam int PORT_DATA    = 1;
  localparam int DEF_MAX_HOLD = 15;
  localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Arbiter bus: req0/req1/done in; gnt0/gnt1/sel/start/busy/err out.
// slave = arbiter side, master = requester/memory side.
interface mem_port_arbiter_if;

  logic req0;
  logic req1;
  logic done;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic start;
  logic busy;
  logic err;

  modport slave (
    input  req0, req1, done,
    output gnt0, gnt1, sel, start, busy, err
  );

  modport master (
    output req0, req1, done,
    input  gnt0, gnt1, sel, start, busy, err
  );

endinterface

// File: rtl/arb_hold_cnt.sv
// Saturating grant-hold counter: clr, en in; tc out.
// tc flags the cycle in which the count would reach MAX_HOLD.
module arb_hold_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL =
    CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Grant cycle MAX_HOLD is the one with cnt == MAX_HOLD-1.
  assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter (fetch=0, data=1) for shared memory.
// Ports: clk, rst_n, bus (slave). Macro MEM_ARB_TIMEOUT_EN adds watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  state_t state_q, state_d;
  logic   lru_q, lru_d;
  logic   start_q, start_d;
  logic   cur;
  logic   tc;
  logic   in_gnt;

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q;
  logic tmo;
`endif

  assign in_gnt = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    lru_d   = lru_q;
    cur     = (state_q == ST_G1);
`ifdef MEM_ARB_TIMEOUT_EN
    tmo     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = lru_q ? ST_G0 : ST_G1;
        end else if (bus.req0) begin
          state_d = ST_G0;
        end else if (bus.req1) begin
          state_d = ST_G1;
        end
      end
      ST_G0, ST_G1: begin
        if (bus.done) begin
          lru_d = cur;
          // Other port first, then re-grant.
          if (cur ? bus.req0 : bus.req1) begin
            state_d = cur ? ST_G0 : ST_G1;
          end else if (cur ? bus.req1 : bus.req0) begin
            state_d = state_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tc) begin
          state_d = ST_IDLE;
          lru_d   = cur;
          tmo     = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    start_d = (state_d != ST_IDLE) &&
              (!in_gnt || bus.done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lru_q   <= 1'b1;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
      start_q <= start_d;
    end
  end

  arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_d),
    .en    (in_gnt),
    .tc    (tc)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (tmo) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err = err_q;
`else
  logic unused_tc;
  assign unused_tc = tc;
  assign bus.err   = 1'b0;
`endif

  assign bus.gnt0  = (state_q == ST_G0);
  assign bus.gnt1  = (state_q == ST_G1);
  assign bus.sel   = (state_q == ST_G1);
  assign bus.busy  = in_gnt;
  assign bus.start = start_q;

endmodule
